// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a 1-cycle-latency single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_data,
  input  logic              m0_rsp_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_data,
  input  logic              m1_rsp_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic                mem_ce_q, mem_ce_d;
  logic                mem_we_q, mem_we_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                gnt0, gnt1;
  logic                any_req;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                own_rsp_ready;
  logic                unused_addr_bits;

  assign any_req = m0_req | m1_req;

`ifdef DMEM_ARB_RR_EN
  // rr_q remembers the last port served; reset value 1 favours port 0.
  logic rr_q, rr_d;

  assign gnt0 = m0_req & (~m1_req | rr_q);
  assign gnt1 = m1_req & ~gnt0;

  always_comb begin
    rr_d = rr_q;
    if (state_q == S_IDLE && any_req) begin
      rr_d = gnt1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b1;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  assign gnt0 = m0_req;
  assign gnt1 = m1_req & ~m0_req;
`endif

  assign sel_we    = gnt1 ? m1_we    : m0_we;
  assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
  assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;

  assign own_rsp_ready = owner_q ? m1_rsp_ready : m0_rsp_ready;

  assign unused_addr_bits = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                              m1_addr[31:ADDR_W+2], m1_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rsp_q       <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rsp_q       <= rsp_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rsp_d       = rsp_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d     = S_ISSUE;
          owner_d     = gnt1;
          mem_ce_d    = 1'b1;
          mem_we_d    = sel_we;
          // Upper address bits dropped: accesses wrap within the memory.
          mem_addr_d  = {{(32-ADDR_W){1'b0}}, sel_addr[ADDR_W+1:2]};
          mem_wdata_d = sel_wdata;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_RESP;
        rsp_d   = mem_rdata;
      end
      S_RESP: begin
        if (own_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    m0_rsp_valid = 1'b0;
    m1_rsp_valid = 1'b0;
    m0_rsp_data  = '0;
    m1_rsp_data  = '0;
    if (!rst && state_q == S_IDLE) begin
      m0_ready = gnt0;
      m1_ready = gnt1;
    end
    if (state_q == S_RESP) begin
      if (owner_q) begin
        m1_rsp_valid = 1'b1;
        m1_rsp_data  = rsp_q;
      end else begin
        m0_rsp_valid = 1'b1;
        m0_rsp_data  = rsp_q;
      end
    end
  end

  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
